// File: rtl/adder_driver.sv
// Self-test driver for a 4-bit adder: sweeps all 256 operand pairs, compares
// the adder's Sum/Overflow against a reference, and reports errors.
module adder_driver #(
  parameter int LATENCY    = 1,
  parameter bit SIGNED_OVF = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       En,
  input  logic [3:0] Sum,
  input  logic       Overflow,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [8:0] ErrCount,
  output logic [3:0] FailA,
  output logic [3:0] FailB
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // WAIT runs with wait_cnt = 0 .. LATENCY-2, i.e. LATENCY-1 cycles.
  localparam logic [3:0] WAIT_LAST = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t     state;
  state_t     state_next;
  logic [7:0] idx;
  logic [7:0] idx_next;
  logic [3:0] wait_cnt;
  logic [3:0] wait_next;
  logic [8:0] err_count;
  logic [8:0] err_next;
  logic [3:0] fail_a;
  logic [3:0] fail_a_next;
  logic [3:0] fail_b;
  logic [3:0] fail_b_next;

  logic [4:0] exp_full;
  logic       exp_ovf;
  logic       mismatch;

  assign A = idx[7:4];
  assign B = idx[3:0];

  assign exp_full = {1'b0, idx[7:4]} + {1'b0, idx[3:0]};
  assign exp_ovf  = SIGNED_OVF ? ((idx[7] == idx[3]) && (exp_full[3] != idx[7]))
                               : exp_full[4];
  assign mismatch = (Sum != exp_full[3:0]) || (Overflow != exp_ovf);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      idx       <= 8'd0;
      wait_cnt  <= 4'd0;
      err_count <= 9'd0;
      fail_a    <= 4'd0;
      fail_b    <= 4'd0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      wait_cnt  <= wait_next;
      err_count <= err_next;
      fail_a    <= fail_a_next;
      fail_b    <= fail_b_next;
    end
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    wait_next   = wait_cnt;
    err_next    = err_count;
    fail_a_next = fail_a;
    fail_b_next = fail_b;
    En          = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;

    case (state)
      IDLE, DONE: begin
        Done = (state == DONE);
        if (Start) begin
          idx_next    = 8'd0;
          err_next    = 9'd0;
          fail_a_next = 4'd0;
          fail_b_next = 4'd0;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        En         = 1'b1;
        Busy       = 1'b1;
        wait_next  = 4'd0;
        state_next = (LATENCY == 1) ? CHECK : WAIT;
      end
      WAIT: begin
        Busy = 1'b1;
        if (wait_cnt == WAIT_LAST) begin
          state_next = CHECK;
        end else begin
          wait_next = wait_cnt + 4'd1;
        end
      end
      CHECK: begin
        Busy = 1'b1;
        // Only the first failing vector of a sweep is captured.
        if (mismatch) begin
          err_next = err_count + 9'd1;
          if (err_count == 9'd0) begin
            fail_a_next = idx[7:4];
            fail_b_next = idx[3:0];
          end
        end
        if (idx == 8'hFF) begin
          state_next = DONE;
        end else begin
          idx_next   = idx + 8'd1;
          state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Pass     = Done && (err_count == 9'd0);
  assign ErrCount = err_count;
  assign FailA    = fail_a;
  assign FailB    = fail_b;

endmodule

// File: tb/tb_adder_driver.sv
// Directed bench for adder_driver: three instances (LATENCY=1 unsigned with
// injectable adder faults, LATENCY=3 unsigned, LATENCY=1 signed overflow).
module tb_adder_driver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   fault = 0;
  int   num_cmp = 0;
  int   num_bad = 0;

  always #5 clk = ~clk;

  // Instance 1: LATENCY=1, unsigned carry
  logic       start1 = 1'b0;
  logic [3:0] a1, b1, fa1, fb1;
  logic [3:0] sum1 = 4'd0;
  logic       ovf1 = 1'b0;
  logic       en1, busy1, done1, pass1;
  logic [8:0] err1;
  logic [4:0] full1;

  adder_driver #(.LATENCY(1), .SIGNED_OVF(1'b0)) dut1 (
    .Clk(clk), .Reset_n(reset_n), .Start(start1), .A(a1), .B(b1), .En(en1),
    .Sum(sum1), .Overflow(ovf1), .Busy(busy1), .Done(done1), .Pass(pass1),
    .ErrCount(err1), .FailA(fa1), .FailB(fb1)
  );

  assign full1 = {1'b0, a1} + {1'b0, b1};
  // fault 1: Sum[0] stuck at 0; fault 2: Overflow tied to 0
  always @(posedge clk) begin
    if (en1) begin
      sum1 <= (fault == 1) ? {full1[3:1], 1'b0} : full1[3:0];
      ovf1 <= (fault == 2) ? 1'b0 : full1[4];
    end
  end

  // Instance 3: LATENCY=3, three-stage adder that emits garbage off-strobe
  logic       start3 = 1'b0;
  logic [3:0] a3, b3, fa3, fb3;
  logic       en3, busy3, done3, pass3;
  logic [8:0] err3;
  logic [4:0] full3;
  logic [4:0] p1 = 5'd0, p2 = 5'd0, p3 = 5'd0;

  adder_driver #(.LATENCY(3), .SIGNED_OVF(1'b0)) dut3 (
    .Clk(clk), .Reset_n(reset_n), .Start(start3), .A(a3), .B(b3), .En(en3),
    .Sum(p3[3:0]), .Overflow(p3[4]), .Busy(busy3), .Done(done3), .Pass(pass3),
    .ErrCount(err3), .FailA(fa3), .FailB(fb3)
  );

  assign full3 = {1'b0, a3} + {1'b0, b3};
  always @(posedge clk) begin
    p1 <= en3 ? full3 : ~full3;
    p2 <= p1;
    p3 <= p2;
  end

  // Instance S: LATENCY=1, two's-complement overflow
  logic       starts = 1'b0;
  logic [3:0] as_, bs, fas, fbs;
  logic [3:0] sums = 4'd0;
  logic       ovfs = 1'b0;
  logic       ens, busys, dones, passs;
  logic [8:0] errs;
  logic [4:0] fulls;

  adder_driver #(.LATENCY(1), .SIGNED_OVF(1'b1)) duts (
    .Clk(clk), .Reset_n(reset_n), .Start(starts), .A(as_), .B(bs), .En(ens),
    .Sum(sums), .Overflow(ovfs), .Busy(busys), .Done(dones), .Pass(passs),
    .ErrCount(errs), .FailA(fas), .FailB(fbs)
  );

  assign fulls = {1'b0, as_} + {1'b0, bs};
  always @(posedge clk) begin
    if (ens) begin
      sums <= fulls[3:0];
      ovfs <= (as_[3] == bs[3]) && (fulls[3] != as_[3]);
    end
  end

  // Runs one sweep on instance 1; cycles is -1 if Done never arrives.
  task automatic run_sweep1(input int pulse_at, output int cycles, output int en_pulses);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    cycles = 0;
    en_pulses = 0;
    while (done1 !== 1'b1 && cycles < 4000) begin
      if (en1) en_pulses++;
      start1 = (cycles == pulse_at);
      @(negedge clk);
      cycles++;
    end
    start1 = 1'b0;
    if (done1 !== 1'b1) cycles = -1;
  endtask

  task automatic test_reset;
    int busy_seen = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    num_cmp++;
    if ({a1, b1, en1, busy1, done1, pass1, err1, fa1, fb1} !== 30'd0) begin
      num_bad++;
      $display("[TB] FAIL reset_outputs1: got %h expected 0",
               {a1, b1, en1, busy1, done1, pass1, err1, fa1, fb1});
    end
    num_cmp++;
    if ({en3, busy3, done3, err3, ens, busys, dones, errs} !== 24'd0) begin
      num_bad++;
      $display("[TB] FAIL reset_outputs3s: got %h expected 0",
               {en3, busy3, done3, err3, ens, busys, dones, errs});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy1 || en1 || done1) busy_seen++;
    end
    num_cmp++;
    if (busy_seen != 0) begin
      num_bad++;
      $display("[TB] FAIL idle_without_start: got %0d active cycles expected 0", busy_seen);
    end
  endtask

  task automatic test_good_sweep;
    int cyc, ens_n;
    fault = 0;
    run_sweep1(-1, cyc, ens_n);
    num_cmp++;
    if (cyc != 512) begin
      num_bad++;
      $display("[TB] FAIL good_duration: got %0d expected 512", cyc);
    end
    num_cmp++;
    if (ens_n != 256) begin
      num_bad++;
      $display("[TB] FAIL good_en_pulses: got %0d expected 256", ens_n);
    end
    num_cmp++;
    if (err1 !== 9'd0 || pass1 !== 1'b1 || busy1 !== 1'b0) begin
      num_bad++;
      $display("[TB] FAIL good_result: got err=%0d pass=%b busy=%b expected err=0 pass=1 busy=0",
               err1, pass1, busy1);
    end
    num_cmp++;
    if (a1 !== 4'hF || b1 !== 4'hF) begin
      num_bad++;
      $display("[TB] FAIL good_idx_no_wrap: got A=%0d B=%0d expected 15 15", a1, b1);
    end
  endtask

  task automatic test_sum_stuck;
    int cyc, ens_n;
    fault = 1;
    run_sweep1(-1, cyc, ens_n);
    num_cmp++;
    if (err1 !== 9'd128) begin
      num_bad++;
      $display("[TB] FAIL sum_stuck_err: got %0d expected 128", err1);
    end
    num_cmp++;
    if (fa1 !== 4'd0 || fb1 !== 4'd1 || pass1 !== 1'b0 || done1 !== 1'b1) begin
      num_bad++;
      $display("[TB] FAIL sum_stuck_fail: got A=%0d B=%0d pass=%b done=%b expected 0 1 0 1",
               fa1, fb1, pass1, done1);
    end
  endtask

  task automatic test_ovf_tied;
    int cyc, ens_n;
    fault = 2;
    run_sweep1(-1, cyc, ens_n);
    num_cmp++;
    if (err1 !== 9'd120) begin
      num_bad++;
      $display("[TB] FAIL ovf_tied_err: got %0d expected 120", err1);
    end
    num_cmp++;
    if (fa1 !== 4'd1 || fb1 !== 4'd15 || pass1 !== 1'b0) begin
      num_bad++;
      $display("[TB] FAIL ovf_tied_fail: got A=%0d B=%0d pass=%b expected 1 15 0", fa1, fb1, pass1);
    end
  endtask

  task automatic test_restart_from_done;
    int cyc = 0;
    fault = 0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    num_cmp++;
    if ({done1, busy1, en1, err1, fa1, fb1, a1, b1} !== {1'b0, 1'b1, 1'b1, 25'd0}) begin
      num_bad++;
      $display("[TB] FAIL restart_clear: got done=%b busy=%b en=%b err=%0d fa=%0d fb=%0d A=%0d B=%0d expected 0 1 1 0 0 0 0 0",
               done1, busy1, en1, err1, fa1, fb1, a1, b1);
    end
    while (done1 !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    num_cmp++;
    if (cyc != 512 || pass1 !== 1'b1) begin
      num_bad++;
      $display("[TB] FAIL restart_sweep: got cycles=%0d pass=%b expected 512 1", cyc, pass1);
    end
  endtask

  task automatic test_latency3;
    int cyc = 0, ens_n = 0, last = 0, bad_gap = 0;
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    while (done3 !== 1'b1 && cyc < 8000) begin
      if (en3) begin
        if (ens_n > 0 && cyc - last != 4) bad_gap++;
        last = cyc;
        ens_n++;
      end
      @(negedge clk);
      cyc++;
    end
    num_cmp++;
    if (cyc != 1024) begin
      num_bad++;
      $display("[TB] FAIL lat3_duration: got %0d expected 1024", cyc);
    end
    num_cmp++;
    if (ens_n != 256 || bad_gap != 0) begin
      num_bad++;
      $display("[TB] FAIL lat3_en_spacing: got pulses=%0d bad_gaps=%0d expected 256 0", ens_n, bad_gap);
    end
    num_cmp++;
    if (err3 !== 9'd0 || pass3 !== 1'b1) begin
      num_bad++;
      $display("[TB] FAIL lat3_result: got err=%0d pass=%b expected 0 1", err3, pass3);
    end
  endtask

  task automatic test_signed;
    int cyc = 0;
    @(negedge clk) starts = 1'b1;
    @(negedge clk) starts = 1'b0;
    while (dones !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    num_cmp++;
    if (cyc != 512 || errs !== 9'd0 || passs !== 1'b1) begin
      num_bad++;
      $display("[TB] FAIL signed_sweep: got cycles=%0d err=%0d pass=%b expected 512 0 1", cyc, errs, passs);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, ens_n;
    fault = 1;
    run_sweep1(101, cyc, ens_n);
    num_cmp++;
    if (cyc != 512 || ens_n != 256) begin
      num_bad++;
      $display("[TB] FAIL midstart_timing: got cycles=%0d pulses=%0d expected 512 256", cyc, ens_n);
    end
    num_cmp++;
    if (err1 !== 9'd128 || fa1 !== 4'd0 || fb1 !== 4'd1) begin
      num_bad++;
      $display("[TB] FAIL midstart_errors: got err=%0d fa=%0d fb=%0d expected 128 0 1", err1, fa1, fb1);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int active = 0;
    fault = 1;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    repeat (200) @(negedge clk);
    num_cmp++;
    if (a1 !== 4'd6 || b1 !== 4'd4 || en1 !== 1'b1 || err1 !== 9'd50) begin
      num_bad++;
      $display("[TB] FAIL vec100_state: got A=%0d B=%0d en=%b err=%0d expected 6 4 1 50", a1, b1, en1, err1);
    end
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    num_cmp++;
    if ({a1, b1, en1, busy1, done1, pass1, err1, fa1, fb1} !== 30'd0) begin
      num_bad++;
      $display("[TB] FAIL midreset_outputs: got %h expected 0",
               {a1, b1, en1, busy1, done1, pass1, err1, fa1, fb1});
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done1 || busy1 || en1) active++;
    end
    num_cmp++;
    if (active != 0) begin
      num_bad++;
      $display("[TB] FAIL midreset_no_done: got %0d active cycles expected 0", active);
    end
  endtask

  initial begin
    test_reset();
    test_good_sweep();
    test_sum_stuck();
    test_ovf_tied();
    test_restart_from_done();
    test_latency3();
    test_signed();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_bad);
    $finish;
  end

endmodule

// File: doc/adder_driver.md
ADDER_DRIVER -- requirements
Module: adder_driver

Interface
REQ-001 The block SHALL have parameter LATENCY, default 1, meaning the number of cycles from the cycle En is high to the cycle Sum/Overflow are valid, with legal range 1..15.
REQ-002 The block SHALL have parameter SIGNED_OVF, default 0, meaning 0 selects unsigned carry-out as the expected Overflow and 1 selects two's-complement overflow.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port Reset_n, input, 1 bit: synchronous active-low reset, sampled only on the rising edge of Clk.
REQ-005 The block SHALL have port Start, input, 1 bit: a one-cycle request to run a full test sweep.
REQ-006 The block SHALL have port A, output, 4 bits: first operand driven to the adder under test.
REQ-007 The block SHALL have port B, output, 4 bits: second operand driven to the adder under test.
REQ-008 The block SHALL have port En, output, 1 bit: a one-cycle issue strobe to the adder under test.
REQ-009 The block SHALL have port Sum, input, 4 bits: result returned by the adder under test.
REQ-010 The block SHALL have port Overflow, input, 1 bit: overflow flag returned by the adder under test.
REQ-011 The block SHALL have port Busy, output, 1 bit: high while a sweep is in progress.
REQ-012 The block SHALL have port Done, output, 1 bit: high when a sweep has completed, held until the next accepted Start or reset.
REQ-013 The block SHALL have port Pass, output, 1 bit: equals Done AND (ErrCount==0).
REQ-014 The block SHALL have port ErrCount, output, 9 bits: number of mismatching vectors in the current or last sweep.
REQ-015 The block SHALL have port FailA, output, 4 bits: A of the first mismatching vector, 0 if none.
REQ-016 The block SHALL have port FailB, output, 4 bits: B of the first mismatching vector, 0 if none.

Function
REQ-017 The block SHALL implement the states IDLE, ISSUE, WAIT, CHECK and DONE.
REQ-018 The block SHALL keep an 8-bit vector index idx, drive A=idx[7:4] and B=idx[3:0], and sweep idx from 0 to 255 in increasing order.
REQ-019 In IDLE or DONE, Start=1 SHALL clear idx, ErrCount, FailA and FailB, drop Done, and move to ISSUE on the next cycle.
REQ-020 Start SHALL be ignored while Busy=1.
REQ-021 In ISSUE, the block SHALL drive En=1 for exactly one cycle with the current A and B, then go to WAIT, or go directly to CHECK when LATENCY=1.
REQ-022 WAIT SHALL last LATENCY-1 cycles, so that CHECK occurs exactly LATENCY cycles after the En cycle.
REQ-023 A and B SHALL remain stable from ISSUE through CHECK of the same vector.
REQ-024 In CHECK, the expected Sum SHALL be (A+B) mod 16.
REQ-025 In CHECK, the expected Overflow SHALL be bit 4 of the 5-bit sum A+B when SIGNED_OVF=0, and (A[3]==B[3]) AND (Sum_exp[3]!=A[3]) when SIGNED_OVF=1.
REQ-026 A mismatch on either Sum or Overflow SHALL increment ErrCount by 1, counting one error per vector.
REQ-027 On the first mismatch of a sweep (ErrCount==0 before the increment), the block SHALL latch FailA=A and FailB=B.
REQ-028 After CHECK, the block SHALL go to ISSUE with idx+1 if idx<255, otherwise to DONE without wrapping idx.
REQ-029 A sweep SHALL take exactly 256*(1+LATENCY) cycles from the first ISSUE cycle to the first cycle of DONE.
REQ-030 Busy SHALL be 1 in ISSUE, WAIT and CHECK, and 0 in IDLE and DONE.
REQ-031 Done SHALL be 1 only in DONE.
REQ-032 En SHALL be 0 outside ISSUE.
REQ-033 Sum and Overflow SHALL be ignored outside CHECK.

Reset
REQ-034 When Reset_n=0 at a rising edge, the block SHALL enter IDLE with A=0, B=0, En=0, Busy=0, Done=0, Pass=0, ErrCount=0, FailA=0, FailB=0 and idx=0.
REQ-035 Reset_n=0 SHALL override Start and abort any sweep in progress, with no Done produced for the aborted sweep.
REQ-036 After Reset_n returns high, the block SHALL remain in IDLE until Start=1 is sampled.

Verification
REQ-037 Scenario: correct registered adder model, LATENCY=1, SIGNED_OVF=0, Start pulse -> 256 En pulses, Done rises 512 cycles after the first ISSUE cycle, ErrCount=0, Pass=1.
REQ-038 Scenario: adder model with Sum[0] stuck at 0 -> ErrCount=128, FailA=0, FailB=1, Pass=0.
REQ-039 Scenario: adder model with Overflow tied to 0 and SIGNED_OVF=0 -> ErrCount=120, FailA=1, FailB=15.
REQ-040 Scenario: LATENCY=3 with a matching 3-stage adder model -> exactly 2 idle cycles between each En pulse and the corresponding CHECK, Done after 1024 cycles, ErrCount=0.
REQ-041 Scenario: Start repulsed mid-sweep -> ignored, with idx and ErrCount continuing without disturbance.
REQ-042 Scenario: Reset_n=0 for 1 cycle at vector 100 -> all outputs at reset values next cycle, and no Done until a new Start.
